count_sequencer: RTL

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_sequencer.sv | 84 ++++++++
 1 files changed

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - command-driven sequencer for an external loadable up/down counter
// Runs reps passes of load-then-count-to-terminal; abort and reset cancel a sequence at any point.
module count_sequencer #(
  parameter int WIDTH  = 8,
  parameter int REPS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_start,
  input  logic              cmd_dir,
  input  logic [REPS_W-1:0] cmd_reps,
  input  logic              abort,
  output logic              cnt_load,
  output logic [WIDTH-1:0]  cnt_load_value,
  output logic              cnt_enable,
  output logic              cnt_direction,
  input  logic              cnt_done,
  output logic              busy,
  output logic              run_done,
  output logic              aborted,
  output logic [REPS_W-1:0] reps_left
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   start_reg;
  logic               dir_reg;
  logic [REPS_W-1:0]  reps_reg;
  logic               aborted_reg;
  logic               accept;

  // abort gates the strobes in the same cycle so the counter never sees a load or step once cancelled
  assign cmd_ready      = (state == IDLE) && !abort;
  assign accept         = cmd_valid && cmd_ready;
  assign busy           = (state != IDLE);
  assign cnt_load       = (state == LOAD) && !abort;
  assign cnt_enable     = (state == RUN) && !cnt_done && !abort;
  assign run_done       = (state == DONE) && !abort;
  assign cnt_load_value = start_reg;
  assign cnt_direction  = dir_reg;
  assign reps_left      = reps_reg;
  assign aborted        = aborted_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      start_reg   <= '0;
      dir_reg     <= 1'b0;
      reps_reg    <= '0;
      aborted_reg <= 1'b0;
    end else begin
      aborted_reg <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          start_reg <= cmd_start;
          dir_reg   <= cmd_dir;
          reps_reg  <= cmd_reps;
          state     <= (cmd_reps != '0) ? LOAD : DONE;
        end
      end else if (abort) begin
        // remaining passes are meaningless after cancellation
        state       <= IDLE;
        aborted_reg <= 1'b1;
        reps_reg    <= '0;
      end else begin
        case (state)
          LOAD: state <= RUN;
          RUN: begin
            if (cnt_done) begin
              reps_reg <= reps_reg - 1'b1;
              state    <= (reps_reg == REPS_W'(1)) ? DONE : LOAD;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
